// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder: access sizes,
// byte-lane enables, store-data replication and alignment checking.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } mem_size_e;

    localparam int DEFAULT_DEPTH_WORDS = 1024;
    localparam int DEFAULT_IDX_W       = $clog2(DEFAULT_DEPTH_WORDS);

    function automatic logic [3:0] byte_enable(input mem_size_e size, input logic [1:0] addr_lo);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << addr_lo;
            SZ_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Right-justified store data is replicated so every enabled lane sees its bytes.
    function automatic logic [31:0] lane_data(input mem_size_e size, input logic [31:0] data);
        logic [31:0] d;
        case (size)
            SZ_BYTE: d = {4{data[7:0]}};
            SZ_HALF: d = {2{data[15:0]}};
            default: d = data;
        endcase
        return d;
    endfunction

    function automatic logic is_misaligned(input mem_size_e size, input logic [1:0] addr_lo);
        logic mis;
        case (size)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = addr_lo[0];
            default: mis = (addr_lo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/dmem_rd_pipe.sv
// Valid+data delay line for load responses; the last stage drives the
// response port and its valid doubles as the retire strobe.
module dmem_rd_pipe #(
    parameter int STAGES = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic        retire
);

    generate
        if (STAGES == 0) begin : g_bypass
            logic unused_clk_rst;
            assign unused_clk_rst = clock ^ reset;
            assign out_valid      = in_valid;
            assign out_data       = in_data;
        end else begin : g_pipe
            logic [STAGES-1:0] valid_q, valid_d;
            logic [31:0]       data_q [STAGES];
            logic [31:0]       data_d [STAGES];

            always_comb begin
                valid_d[0] = in_valid;
                data_d[0]  = in_data;
                for (int i = 1; i < STAGES; i++) begin
                    valid_d[i] = valid_q[i-1];
                    data_d[i]  = data_q[i-1];
                end
            end

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    valid_q <= '0;
                    for (int i = 0; i < STAGES; i++) data_q[i] <= '0;
                end else begin
                    valid_q <= valid_d;
                    for (int i = 0; i < STAGES; i++) data_q[i] <= data_d[i];
                end
            end

            assign out_valid = valid_q[STAGES-1];
            assign out_data  = data_q[STAGES-1];
        end
    endgenerate

    assign retire = out_valid;

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the CPU data port: word-organised storage with
// lane-steered stores and fixed-latency, in-order load responses.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS     = DEFAULT_DEPTH_WORDS,
    parameter int READ_LATENCY    = 2,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        dmem_req_valid,
    input  logic        dmem_req_we,
    input  logic [31:0] dmem_req_addr,
    input  logic [31:0] dmem_req_data,
    input  logic        dmem_req_size_0,
    input  logic        dmem_req_size_1,
    output logic        dmem_req_ready,
    output logic        dmem_resp_valid,
    output logic [31:0] dmem_resp_data,
    output logic        misalign_err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    mem_size_e        req_size;
    logic [IDX_W-1:0] idx;
    logic             accept, load_acc, misaligned, retire;
    logic [3:0]       wr_be;
    logic [31:0]      wr_data;

    assign req_size = mem_size_e'({dmem_req_size_1, dmem_req_size_0});
    assign idx      = dmem_req_addr[IDX_W+1:2];
    assign accept   = dmem_req_valid & dmem_req_ready;

    // Address bits above the index alias onto the same words.
    generate
        if (IDX_W + 2 < 32) begin : g_addr_hi
            logic unused_addr_hi;
            assign unused_addr_hi = ^dmem_req_addr[31:IDX_W+2];
        end
    endgenerate

    always_comb begin
        misaligned = is_misaligned(req_size, dmem_req_addr[1:0]);
        load_acc   = accept & ~dmem_req_we;
        wr_data    = lane_data(req_size, dmem_req_data);
        wr_be      = '0;
        if (accept && dmem_req_we && !misaligned) begin
            wr_be = byte_enable(req_size, dmem_req_addr[1:0]);
        end
    end

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] rd_word_q;

    always_ff @(posedge clock) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_be[i]) mem[idx][8*i +: 8] <= wr_data[8*i +: 8];
        end
        if (load_acc) rd_word_q <= mem[idx];
    end

    logic             started_q, started_d;
    logic             rd_valid_q, rd_valid_d;
    logic             rd_mis_q, rd_mis_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        started_d  = 1'b1;
        rd_valid_d = load_acc;
        rd_mis_d   = load_acc & misaligned;
        err_d      = err_q | (accept & misaligned);
        cnt_d      = cnt_q;
        if (load_acc && !retire) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!load_acc && retire) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            started_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_mis_q   <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            started_q  <= started_d;
            rd_valid_q <= rd_valid_d;
            rd_mis_q   <= rd_mis_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
        end
    end

    // A retiring response frees its slot in the same cycle, so full-rate loads never stall.
    assign dmem_req_ready = started_q & ((cnt_q < CNT_W'(MAX_OUTSTANDING)) | retire);
    assign misalign_err   = err_q;

    logic [31:0] rd_data;
    logic [31:0] pipe_data;

    assign rd_data = rd_mis_q ? 32'h0 : rd_word_q;

    dmem_rd_pipe #(
        .STAGES(READ_LATENCY - 1)
    ) u_rd_pipe (
        .clock    (clock),
        .reset    (reset),
        .in_valid (rd_valid_q),
        .in_data  (rd_data),
        .out_valid(dmem_resp_valid),
        .out_data (pipe_data),
        .retire   (retire)
    );

    assign dmem_resp_data = dmem_resp_valid ? pipe_data : 32'h0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: default instance (latency 2, two
// outstanding) plus a latency-3 / single-outstanding instance.
module tb_dmem_responder;
    import dmem_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        req_valid, req_we, size0, size1;
    logic [31:0] req_addr, req_data;
    logic        ready, resp_valid, err;
    logic [31:0] resp_data;

    logic        b_valid, b_we, b_size0, b_size1;
    logic [31:0] b_addr, b_data;
    logic        b_ready, b_resp_valid, b_err;
    logic [31:0] b_resp_data;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dmem_responder dut (
        .clock(clk), .reset(rst_n),
        .dmem_req_valid(req_valid), .dmem_req_we(req_we),
        .dmem_req_addr(req_addr), .dmem_req_data(req_data),
        .dmem_req_size_0(size0), .dmem_req_size_1(size1),
        .dmem_req_ready(ready), .dmem_resp_valid(resp_valid),
        .dmem_resp_data(resp_data), .misalign_err(err)
    );

    dmem_responder #(.DEPTH_WORDS(1024), .READ_LATENCY(3), .MAX_OUTSTANDING(1)) dut_l3 (
        .clock(clk), .reset(rst_n),
        .dmem_req_valid(b_valid), .dmem_req_we(b_we),
        .dmem_req_addr(b_addr), .dmem_req_data(b_data),
        .dmem_req_size_0(b_size0), .dmem_req_size_1(b_size1),
        .dmem_req_ready(b_ready), .dmem_resp_valid(b_resp_valid),
        .dmem_resp_data(b_resp_data), .misalign_err(b_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_req(input logic we, input logic [31:0] addr, input logic [31:0] data,
                           input logic [1:0] size);
        req_valid    = 1'b1;
        req_we       = we;
        req_addr     = addr;
        req_data     = data;
        {size1, size0} = size;
    endtask

    // Called just after a falling edge; returns on the falling edge after the accept.
    task automatic store(input string tag, input logic [31:0] addr, input logic [31:0] data,
                         input logic [1:0] size);
        $display("[TB] store %s addr=0x%08h data=0x%08h size=%0d", tag, addr, data, size);
        set_req(1'b1, addr, data, size);
        #1 check_eq({tag, "_rdy"}, 32'(ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Response must be absent one edge after accept and present on the second.
    task automatic load(input string tag, input logic [31:0] addr, input logic [1:0] size,
                        input logic [31:0] exp);
        $display("[TB] load  %s addr=0x%08h size=%0d expect=0x%08h", tag, addr, size, exp);
        set_req(1'b0, addr, 32'h0, size);
        #1 check_eq({tag, "_rdy"}, 32'(ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        check_eq({tag, "_rv_early"}, 32'(resp_valid), 32'd0);
        @(negedge clk);
        check_eq({tag, "_rv"}, 32'(resp_valid), 32'd1);
        check_eq({tag, "_data"}, resp_data, exp);
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_data = '0; size0 = 1'b0; size1 = 1'b0;
        b_valid = 1'b0; b_we = 1'b0; b_addr = '0; b_data = '0; b_size0 = 1'b0; b_size1 = 1'b0;

        repeat (2) @(negedge clk);
        check_eq("rst_ready", 32'(ready), 32'd0);
        check_eq("rst_rv", 32'(resp_valid), 32'd0);
        check_eq("rst_data", resp_data, 32'h0);
        check_eq("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        #1 check_eq("rdy_before_edge", 32'(ready), 32'd0);
        @(negedge clk);
        check_eq("rdy_after_edge", 32'(ready), 32'd1);

        // Word store followed immediately by a load of the same word
        store("w40", 32'h40, 32'hDEADBEEF, SZ_WORD);
        load("w40", 32'h40, SZ_WORD, 32'hDEADBEEF);
        @(negedge clk);
        check_eq("w40_pulse_end", 32'(resp_valid), 32'd0);

        // Sub-word lane steering; junk above the right-justified field must not land
        store("z80", 32'h80, 32'h00000000, SZ_WORD);
        store("b81", 32'h81, 32'h123456AA, SZ_BYTE);
        store("h82", 32'h82, 32'hABCD1234, SZ_HALF);
        load("l80", 32'h80, SZ_WORD, 32'h1234AA00);
        load("lb81", 32'h81, SZ_BYTE, 32'h1234AA00);

        // Back-to-back loads at full rate
        store("s0", 32'h0, 32'h11111111, SZ_WORD);
        store("s4", 32'h4, 32'h22222222, SZ_WORD);
        store("s8", 32'h8, 32'h33333333, SZ_WORD);
        $display("[TB] load  bb burst 0x0/0x4/0x8");
        set_req(1'b0, 32'h0, 32'h0, SZ_WORD);
        #1 check_eq("bb_rdy0", 32'(ready), 32'd1);
        @(negedge clk);
        check_eq("bb_rdy1", 32'(ready), 32'd1);
        check_eq("bb_rv_e0", 32'(resp_valid), 32'd0);
        set_req(1'b0, 32'h4, 32'h0, SZ_WORD);
        @(negedge clk);
        check_eq("bb_rdy2_full", 32'(ready), 32'd1);
        check_eq("bb_rv0", 32'(resp_valid), 32'd1);
        check_eq("bb_d0", resp_data, 32'h11111111);
        set_req(1'b0, 32'h8, 32'h0, SZ_WORD);
        @(negedge clk);
        req_valid = 1'b0;
        check_eq("bb_rv1", 32'(resp_valid), 32'd1);
        check_eq("bb_d1", resp_data, 32'h22222222);
        @(negedge clk);
        check_eq("bb_rv2", 32'(resp_valid), 32'd1);
        check_eq("bb_d2", resp_data, 32'h33333333);
        @(negedge clk);
        check_eq("bb_rv_end", 32'(resp_valid), 32'd0);
        check_eq("bb_rdy_end", 32'(ready), 32'd1);

        // Misaligned accesses
        check_eq("err_clean", 32'(err), 32'd0);
        store("mis_st", 32'h42, 32'hFFFFFFFF, SZ_WORD);
        check_eq("err_set", 32'(err), 32'd1);
        load("mis_chk40", 32'h40, SZ_WORD, 32'hDEADBEEF);
        load("mis_ld43", 32'h43, SZ_HALF, 32'h00000000);
        store("good44", 32'h44, 32'h01020304, SZ_WORD);
        load("good44", 32'h44, SZ_WORD, 32'h01020304);
        check_eq("err_sticky", 32'(err), 32'd1);

        // Address aliasing above the index range
        store("wrap", 32'h1000, 32'h00000055, SZ_WORD);
        load("wrap0", 32'h0, SZ_WORD, 32'h00000055);

        // Reset with a load in flight
        store("s100", 32'h100, 32'hCAFEF00D, SZ_WORD);
        $display("[TB] load  0x100 then reset in flight");
        set_req(1'b0, 32'h100, 32'h0, SZ_WORD);
        @(negedge clk);
        req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_eq("mrst_rv", 32'(resp_valid), 32'd0);
        check_eq("mrst_ready", 32'(ready), 32'd0);
        check_eq("mrst_data", resp_data, 32'h0);
        check_eq("mrst_err", 32'(err), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("mrst_no_resp", 32'(resp_valid), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("post_rst_rv", 32'(resp_valid), 32'd0);
        load("kept100", 32'h100, SZ_WORD, 32'hCAFEF00D);
        load("kept40", 32'h40, SZ_WORD, 32'hDEADBEEF);

        // Latency 3, one outstanding: ready drops for two cycles after each load
        $display("[TB] l3 store 0x10 data=0x0badcafe");
        b_valid = 1'b1; b_we = 1'b1; b_addr = 32'h10; b_data = 32'h0BADCAFE;
        {b_size1, b_size0} = SZ_WORD;
        #1 check_eq("l3_st_rdy", 32'(b_ready), 32'd1);
        @(negedge clk);
        $display("[TB] l3 load  0x10 expect=0x0badcafe");
        b_we = 1'b0;
        #1 check_eq("l3_ld_rdy", 32'(b_ready), 32'd1);
        @(negedge clk);
        b_valid = 1'b0;
        check_eq("l3_rdy_e0", 32'(b_ready), 32'd0);
        check_eq("l3_rv_e0", 32'(b_resp_valid), 32'd0);
        @(negedge clk);
        check_eq("l3_rdy_e1", 32'(b_ready), 32'd0);
        check_eq("l3_rv_e1", 32'(b_resp_valid), 32'd0);
        @(negedge clk);
        check_eq("l3_rdy_e2", 32'(b_ready), 32'd1);
        check_eq("l3_rv_e2", 32'(b_resp_valid), 32'd1);
        check_eq("l3_data", b_resp_data, 32'h0BADCAFE);
        @(negedge clk);
        check_eq("l3_rv_end", 32'(b_resp_valid), 32'd0);
        check_eq("l3_rdy_end", 32'(b_ready), 32'd1);
        check_eq("l3_err", 32'(b_err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
